fifo_reader: RTL and testbench

Read-side engine for the `fifo` block, the counterpart to the write driver. It pops a programmed number of words from a `fifo` instance using its `read`/`empty`/`full` handshake and presents each popped word as a registered output stream with an index. Optionally it waits for `full` before each drain burst, and it can check popped data against an arithmetic sequence. It sits directly on the FIFO read port, in benches and in datapaths that consume FIFO contents.

---
 rtl/fifo_reader_pkg.sv | 15 +
 rtl/fifo_reader_checker.sv | 38 +++
 rtl/fifo_reader.sv | 142 ++++++++++++++
 tb/tb_fifo_reader.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_reader_pkg.sv
// Shared types and default widths for the fifo_reader read-side engine.
package fifo_reader_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_CNT_WIDTH  = 32;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FILL_WAIT = 3'd1,
    DRAIN     = 3'd2,
    FLUSH     = 3'd3,
    DONE      = 3'd4
  } state_e;

endpackage

// File: rtl/fifo_reader_checker.sv
// Compares presented words against CHK_BASE + index*CHK_STRIDE; saturating error count.
// Built only when FIFO_READER_CHECK_EN is defined.
`ifdef FIFO_READER_CHECK_EN
module fifo_reader_checker
  import fifo_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int unsigned CHK_BASE   = 0,
  parameter int unsigned CHK_STRIDE = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  out_valid,
  input  logic [CNT_WIDTH-1:0]  out_index,
  input  logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  err_count
);

  logic [DATA_WIDTH-1:0] expected_c;

  always_comb begin
    expected_c = DATA_WIDTH'(CHK_BASE) + DATA_WIDTH'(out_index) * DATA_WIDTH'(CHK_STRIDE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      err_count <= '0;
    end else if (clear) begin
      err_count <= '0;
    end else if (out_valid && (out_data != expected_c) && (err_count != '1)) begin
      err_count <= err_count + CNT_WIDTH'(1);
    end
  end

endmodule
`endif

// File: rtl/fifo_reader.sv
// Pops word_count words from a FIFO read port and presents them as an indexed stream.
// Optional data checker is built when FIFO_READER_CHECK_EN is defined.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int unsigned CHK_BASE   = 0,
  parameter int unsigned CHK_STRIDE = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  burst_mode,
  input  logic [CNT_WIDTH-1:0]  word_count,
  input  logic [DATA_WIDTH-1:0] fifo_output_data,
  input  logic                  fifo_empty,
  input  logic                  fifo_full,
  output logic                  fifo_read,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic [CNT_WIDTH-1:0]  out_index,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  err_count
);

  localparam int unsigned CW1 = CNT_WIDTH + 1;

  state_e                state, state_next;
  logic                  burst_q;
  logic [CNT_WIDTH-1:0]  count_q;
  logic [CNT_WIDTH-1:0]  issued_q;
  logic [CNT_WIDTH-1:0]  captured_q;
  logic                  pop_d1_q;

  logic                  start_accept_c;
  logic                  pop_now_c;
  logic [CW1-1:0]        issued_next_c;
  logic [CW1-1:0]        presented_next_c;
  logic                  words_left_c;
  logic                  read_d, busy_d, done_d;

  // Pop bookkeeping; widened by one bit so the compares cannot overflow.
  always_comb begin
    start_accept_c   = (state == IDLE) && start;
    pop_now_c        = fifo_read && !fifo_empty;
    issued_next_c    = CW1'(issued_q) + CW1'(pop_now_c);
    presented_next_c = CW1'(captured_q) + CW1'(pop_d1_q);
    words_left_c     = issued_next_c < CW1'(count_q);
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (word_count == '0) state_next = DONE;
          else if (burst_mode)  state_next = FILL_WAIT;
          else                  state_next = DRAIN;
        end
      end
      FILL_WAIT: if (fifo_full) state_next = DRAIN;
      DRAIN: begin
        if (!words_left_c)                state_next = FLUSH;
        else if (burst_q && fifo_empty)   state_next = FILL_WAIT;
      end
      // Exit once the final word sits in the capture stage, so done trails its out_valid by one.
      FLUSH: if (presented_next_c == CW1'(count_q)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    read_d = 1'b0;
    busy_d = state_next != IDLE;
    done_d = state == DONE;
    if ((state == DRAIN) && !fifo_empty && words_left_c) read_d = 1'b1;
  end

  // Registered outputs, read pipeline and transfer counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fifo_read  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_index  <= '0;
      pop_d1_q   <= 1'b0;
      burst_q    <= 1'b0;
      count_q    <= '0;
      issued_q   <= '0;
      captured_q <= '0;
    end else begin
      fifo_read <= read_d;
      busy      <= busy_d;
      done      <= done_d;
      pop_d1_q  <= pop_now_c;
      out_valid <= pop_d1_q;
      if (pop_d1_q) begin
        out_data   <= fifo_output_data;
        out_index  <= captured_q;
        captured_q <= captured_q + CNT_WIDTH'(1);
      end
      if (pop_now_c) issued_q <= issued_q + CNT_WIDTH'(1);
      if (start_accept_c) begin
        count_q    <= word_count;
        burst_q    <= burst_mode;
        issued_q   <= '0;
        captured_q <= '0;
      end
    end
  end

`ifdef FIFO_READER_CHECK_EN
  fifo_reader_checker #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH),
    .CHK_BASE   (CHK_BASE),
    .CHK_STRIDE (CHK_STRIDE)
  ) u_checker (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_accept_c),
    .out_valid (out_valid),
    .out_index (out_index),
    .out_data  (out_data),
    .err_count (err_count)
  );
`else
  // No checker: the count is a constant zero.
  assign err_count = CNT_WIDTH'(CHK_BASE * 0 + CHK_STRIDE * 0);
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader with a behavioural FIFO (read latency 1) and a streaming writer.
module tb_fifo_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        burst_mode;
  logic [31:0] word_count;
  logic [31:0] fifo_output_data;
  logic        fifo_empty;
  logic        fifo_full;
  logic        fifo_read;
  logic [31:0] out_data;
  logic        out_valid;
  logic [31:0] out_index;
  logic        busy;
  logic        done;
  logic [31:0] err_count;

  fifo_reader dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .burst_mode       (burst_mode),
    .word_count       (word_count),
    .fifo_output_data (fifo_output_data),
    .fifo_empty       (fifo_empty),
    .fifo_full        (fifo_full),
    .fifo_read        (fifo_read),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_index        (out_index),
    .busy             (busy),
    .done             (done),
    .err_count        (err_count)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO
  logic [31:0] mem [64];
  int          cnt = 0, rd_ptr = 0, wr_ptr = 0;
  int          fifo_depth = 16;
  logic        fifo_clr = 1'b0;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        m_pop, m_push;

  assign fifo_empty = (cnt == 0);
  assign fifo_full  = (cnt == fifo_depth);
  assign m_pop      = fifo_read && (cnt != 0);
  assign m_push     = wr_en && (cnt < fifo_depth);

  always @(posedge clk) begin
    if (fifo_clr) begin
      cnt <= 0; rd_ptr <= 0; wr_ptr <= 0;
    end else begin
      if (m_pop) begin
        fifo_output_data <= mem[rd_ptr];
        rd_ptr <= (rd_ptr + 1) % 64;
      end
      if (m_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr <= (wr_ptr + 1) % 64;
      end
      cnt <= cnt + int'(m_push) - int'(m_pop);
    end
  end

  // Writer: pushes word (i*2) for i = wr_idx - wr_base while below wr_target and not full
  int wr_idx = 0, wr_base = 0, wr_target = 0, corrupt_pos = -1;

  initial begin
    wr_en = 1'b0;
    wr_data = '0;
    forever begin
      @(negedge clk);
      if (wr_idx < wr_target && !fifo_full) begin
        wr_en   = 1'b1;
        wr_data = ((wr_idx - wr_base) == corrupt_pos) ? 32'hFF : 32'(2 * (wr_idx - wr_base));
        wr_idx++;
      end else begin
        wr_en = 1'b0;
      end
    end
  end

  int checks = 0, failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-transfer observations
  logic [31:0] q_data[$];
  logic [31:0] q_idx[$];
  int first_rd, first_vld, last_vld, done_cyc, done_cnt, pops, rd_cnt, rd_pre_full;
  bit saw_full;
  logic busy_c1, busy_at_done, busy_after;
  logic [31:0] err_at_done;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fifo_clear();
    wr_target = wr_idx;
    corrupt_pos = -1;
    step(); step();
    fifo_clr = 1'b1;
    step();
    fifo_clr = 1'b0;
  endtask

  task automatic fill(input int n);
    wr_base   = wr_idx;
    wr_target = wr_idx + n;
    for (int i = 0; i < 200 && wr_idx < wr_target; i++) step();
    step(); step();
    check_eq("fill_cnt", 64'(cnt), 64'(n));
  endtask

  task automatic run_txn(input bit b, input int wc, input int budget);
    q_data.delete(); q_idx.delete();
    first_rd = -1; first_vld = -1; last_vld = -1; done_cyc = -1;
    done_cnt = 0; pops = 0; rd_cnt = 0; rd_pre_full = 0; saw_full = 0;
    busy_c1 = 1'b0; busy_at_done = 1'b1; busy_after = 1'b1; err_at_done = '0;
    burst_mode = b; word_count = 32'(wc); start = 1'b1;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      step();
      if (cyc == 1) begin start = 1'b0; busy_c1 = busy; end
      if (fifo_read) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = cyc;
        if (!saw_full) rd_pre_full++;
      end
      if (fifo_read && !fifo_empty) pops++;
      if (fifo_full) saw_full = 1'b1;
      if (out_valid) begin
        q_data.push_back(out_data);
        q_idx.push_back(out_index);
        if (first_vld < 0) first_vld = cyc;
        last_vld = cyc;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = cyc; busy_at_done = busy; err_at_done = err_count; end
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after = busy;
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
    end
    check_eq("done_once", 64'(done_cnt), 64'd1);
  endtask

  task automatic check_stream(input string tag, input int n);
    check_eq({tag, "_nwords"}, 64'(q_data.size()), 64'(n));
    for (int i = 0; i < q_data.size() && i < n; i++) begin
      check_eq($sformatf("%s_idx%0d", tag, i), 64'(q_idx[i]), 64'(i));
      check_eq($sformatf("%s_data%0d", tag, i), 64'(q_data[i]),
               (i == corrupt_pos) ? 64'hFF : 64'(2 * i));
    end
  endtask

  localparam logic [31:0] EXP_ERR_CORRUPT =
`ifdef FIFO_READER_CHECK_EN
    32'd1;
`else
    32'd0;
`endif

  initial begin
    reset = 1'b0; start = 1'b0; burst_mode = 1'b0; word_count = '0;
    repeat (3) step();
    check_eq("rst_fifo_read", 64'(fifo_read), 64'd0);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_out_index", 64'(out_index), 64'd0);
    check_eq("rst_err", 64'(err_count), 64'd0);
    reset = 1'b1;
    step();

    // 1: 16 preloaded words, streaming mode
    fifo_depth = 16;
    fill(16);
    run_txn(1'b0, 16, 100);
    check_eq("t1_first_read_cyc", 64'(first_rd), 64'd2);
    check_eq("t1_first_valid_cyc", 64'(first_vld), 64'd4);
    check_eq("t1_busy_cyc1", 64'(busy_c1), 64'd1);
    check_eq("t1_done_after_last", 64'(done_cyc - last_vld), 64'd1);
    check_eq("t1_busy_at_done", 64'(busy_at_done), 64'd0);
    check_eq("t1_err", 64'(err_at_done), 64'd0);
    check_stream("t1", 16);

    // 2: burst mode, writer streams 32 words into a depth-16 FIFO
    fifo_clear();
    wr_base = wr_idx; wr_target = wr_idx + 32;
    run_txn(1'b1, 32, 300);
    check_eq("t2_read_before_full", 64'(rd_pre_full), 64'd0);
    check_eq("t2_pops", 64'(pops), 64'd32);
    check_eq("t2_done_after_last", 64'(done_cyc - last_vld), 64'd1);
    check_stream("t2", 32);

    // 3: 20 words held, only 5 requested
    fifo_clear();
    fifo_depth = 32;
    fill(20);
    run_txn(1'b0, 5, 100);
    check_eq("t3_pops", 64'(pops), 64'd5);
    check_eq("t3_left_in_fifo", 64'(cnt), 64'd15);
    check_eq("t3_busy_after_done", 64'(busy_after), 64'd0);
    check_stream("t3", 5);

    // 4: zero-length transfer
    run_txn(1'b0, 0, 20);
    check_eq("t4_reads", 64'(rd_cnt), 64'd0);
    check_eq("t4_done_cyc", 64'(done_cyc), 64'd2);
    check_eq("t4_nwords", 64'(q_data.size()), 64'd0);

    // 5: word 3 corrupted
    fifo_clear();
    fifo_depth = 16;
    corrupt_pos = 3;
    fill(8);
    run_txn(1'b0, 8, 100);
    check_eq("t5_err_at_done", 64'(err_at_done), 64'(EXP_ERR_CORRUPT));
    check_stream("t5", 8);
    corrupt_pos = -1;

    // 6: reset in the middle of a 32-word transfer, then a clean rerun
    fifo_clear();
    wr_base = wr_idx; wr_target = wr_idx + 32;
    burst_mode = 1'b0; word_count = 32'd32; start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    check_eq("t6_midway_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    step();
    check_eq("t6_rst_fifo_read", 64'(fifo_read), 64'd0);
    check_eq("t6_rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("t6_rst_out_data", 64'(out_data), 64'd0);
    check_eq("t6_rst_out_index", 64'(out_index), 64'd0);
    check_eq("t6_rst_busy", 64'(busy), 64'd0);
    check_eq("t6_rst_done", 64'(done), 64'd0);
    check_eq("t6_rst_err", 64'(err_count), 64'd0);
    fifo_clear();
    reset = 1'b1;
    step();
    fill(4);
    run_txn(1'b0, 4, 60);
    check_stream("t6", 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
